lc3_mem_arbiter: RTL and testbench
==================================

# lc3_mem_arbiter

Sequencer and arbiter that shares the single-port, level-sensitive LC-3 RAM between the instruction-fetch unit (read-only) and the load/store unit (read/write). Requests use a REQ/ACK handshake; a 2-way round-robin picks the winner. A small FSM drives the RAM address, write-enable and write data so that WE is asserted only while the address is stable. It sits between the LC-3 control/datapath and the RAM instance.

## Interface
- ADDR_SIZE, 16, address width in bits.
- DATA_SIZE, 16, data width in bits.
- WAIT_CYCLES, 1, number of cycles the RAM access is held. Legal range is 1 or more; 0 behaves as 1.

- CLK  in  1  single clock. All state changes on the rising edge.
- RESET_N  in  1  reset, asynchronous and active-low.
- IF_REQ  in  1  fetch request. Held high with IF_ADDR stable until IF_ACK.
- IF_ADDR  in  ADDR_SIZE  fetch address.
- IF_RDATA  out  DATA_SIZE  fetched word.
- IF_ACK  out  1  one-cycle pulse marking completion of a fetch.
- LS_REQ  in  1  load/store request. Held high with LS_WE, LS_ADDR and LS_WDATA stable until LS_ACK.
- LS_WE  in  1  1 = store, 0 = load.
- LS_ADDR  in  ADDR_SIZE  load/store address.
- LS_WDATA  in  DATA_SIZE  store data.
- LS_RDATA  out  DATA_SIZE  loaded word.
- LS_ACK  out  1  one-cycle pulse marking completion of a load or store.
- RAM_WE  out  1  RAM write enable.
- RAM_ADDRESS  out  ADDR_SIZE  RAM address.
- RAM_DATA_IN  out  DATA_SIZE  RAM write data.
- RAM_DATA_OUT  in  DATA_SIZE  RAM read data (combinational).
- GRANT  out  2  current owner: 2'b00 none, 2'b01 IF, 2'b10 LS.
- BUSY  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: if any REQ is high, the round-robin picks a winner. Address, WE and write data are latched into registers. GRANT is set to the winner and the wait counter is loaded with WAIT_CYCLES-1. Next state is ACCESS.
- IDLE with no REQ: stay in IDLE.
- Round-robin: when both requests are high, the port not granted last time wins. The LAST pointer updates on each grant. After reset, LAST=LS, so IF wins the first tie.
- A lone request always wins, regardless of the pointer.
- ACCESS: RAM_ADDRESS and RAM_DATA_IN come from the latched registers. RAM_WE = latched WE, and only in this state.
- ACCESS counter: decrements each cycle. When the counter is 0, RAM_DATA_OUT is captured into the granted port's RDATA register (loads and fetches only) and the FSM goes to DONE.
- DONE: RAM_WE=0 while RAM_ADDRESS is held. The granted port's ACK is high for exactly this cycle. Next state is always IDLE, and GRANT clears on the IDLE entry.
- RDATA registers hold their value until the next completed read on the same port. Stores leave LS_RDATA unchanged.
- A REQ still high in the IDLE cycle after ACK is treated as a new request. Requesters must drop REQ on the edge where they sample ACK.
- A REQ that drops during ACCESS is ignored: the access completes and ACK still pulses. Requester misbehaviour is not checked.
- A second request arriving during ACCESS or DONE waits in IDLE arbitration. No request is lost while its REQ stays high.

## Timing
- Reset values: all outputs 0, FSM in IDLE, LAST=LS, counter 0, RDATA registers 0.
- Reset asserted mid-access: RAM_WE drops immediately (asynchronous), no ACK is issued, and the in-flight store may be partial.
- Latency: REQ sampled high in IDLE at edge N → ACK high during cycle N+WAIT_CYCLES+1 → RDATA valid from that same cycle.
- Throughput: one access every WAIT_CYCLES+2 cycles. The DONE→IDLE bubble is intentional.
- With WAIT_CYCLES=1, a contested IF/LS pair completes its two ACKs 3 cycles apart.
- RAM_ADDRESS changes only on the IDLE→ACCESS edge, and RAM_WE is never high in IDLE or DONE. This guarantees that no write to a transient address can occur in the level-sensitive RAM.
- All outputs are registered or decoded from the state register only. There are no combinational paths from REQ to RAM_*.

## Structure
- Shared package lc3_mem_pkg holds:
  - the state encoding constants: S_IDLE=2'd0, S_ACCESS=2'd1, S_DONE=2'd2;
  - the GRANT encodings: GNT_NONE, GNT_IF, GNT_LS.
- Sub-module rr_arb2 is the 2-requester round-robin picker. Inputs: CLK, RESET_N, REQ[1:0], UPDATE. Outputs: one-hot WIN[1:0]. It is reusable for future DMA/IO ports.
- The FSM, wait counter and latch registers stay in lc3_mem_arbiter.

## Test plan
- Reset, then IF_REQ with IF_ADDR=16'h0008, RAM model returning 16'h1226 at that address, WAIT_CYCLES=1 → GRANT=01 one cycle after the request is sampled, IF_ACK pulses exactly one cycle, IF_RDATA=16'h1226, RAM_WE stays 0 throughout.
- LS store: LS_ADDR=16'h0020, LS_WDATA=16'hBEEF; then LS load from 16'h0020 → RAM_WE high only in ACCESS cycles, LS_RDATA=16'hBEEF, IF_RDATA unchanged.
- IF_REQ and LS_REQ asserted in the same cycle, both held → IF acknowledged first, LS acknowledged 3 cycles later. Repeat the contention → LS now wins, confirming alternation.
- WAIT_CYCLES=3 → ACK arrives 4 cycles after the request is sampled, and RAM_ADDRESS is constant across all ACCESS cycles.
- RESET_N pulled low during ACCESS of a store → RAM_WE, BUSY and GRANT go to 0 immediately, no ACK. After release, IF wins the first tie.
- LS_REQ held high for 3 consecutive accesses → 3 LS_ACK pulses spaced WAIT_CYCLES+2 cycles apart, with BUSY low for exactly one cycle between accesses.

Source files
------------

// File: rtl/lc3_mem_pkg.sv
// Shared definitions for the LC-3 memory arbiter: FSM state encoding,
// GRANT encodings and a small helper that turns a one-hot winner into a grant code.
package lc3_mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_IF   = 2'b01;
  localparam logic [1:0] GNT_LS   = 2'b10;

  // Bit 0 of a winner vector is the fetch port, bit 1 the load/store port.
  function automatic logic [1:0] win_to_grant(input logic [1:0] win);
    logic [1:0] grant;
    grant = GNT_NONE;
    if (win[1]) begin
      grant = GNT_LS;
    end else if (win[0]) begin
      grant = GNT_IF;
    end
    return grant;
  endfunction

endpackage

// File: rtl/lc3_mem_arbiter_if.sv
// Bus bundle between the LC-3 fetch unit, the load/store unit, the RAM
// and the memory arbiter. The slave side is the arbiter; the master side
// collects everything the arbiter talks to (requesters and RAM).
interface lc3_mem_arbiter_if #(
  parameter int ADDR_SIZE = 16,
  parameter int DATA_SIZE = 16
);

  logic                 IF_REQ;
  logic [ADDR_SIZE-1:0] IF_ADDR;
  logic [DATA_SIZE-1:0] IF_RDATA;
  logic                 IF_ACK;

  logic                 LS_REQ;
  logic                 LS_WE;
  logic [ADDR_SIZE-1:0] LS_ADDR;
  logic [DATA_SIZE-1:0] LS_WDATA;
  logic [DATA_SIZE-1:0] LS_RDATA;
  logic                 LS_ACK;

  logic                 RAM_WE;
  logic [ADDR_SIZE-1:0] RAM_ADDRESS;
  logic [DATA_SIZE-1:0] RAM_DATA_IN;
  logic [DATA_SIZE-1:0] RAM_DATA_OUT;

  logic [1:0]           GRANT;
  logic                 BUSY;

  modport slave (
    input  IF_REQ, IF_ADDR,
    output IF_RDATA, IF_ACK,
    input  LS_REQ, LS_WE, LS_ADDR, LS_WDATA,
    output LS_RDATA, LS_ACK,
    output RAM_WE, RAM_ADDRESS, RAM_DATA_IN,
    input  RAM_DATA_OUT,
    output GRANT, BUSY
  );

  modport master (
    output IF_REQ, IF_ADDR,
    input  IF_RDATA, IF_ACK,
    output LS_REQ, LS_WE, LS_ADDR, LS_WDATA,
    input  LS_RDATA, LS_ACK,
    input  RAM_WE, RAM_ADDRESS, RAM_DATA_IN,
    output RAM_DATA_OUT,
    input  GRANT, BUSY
  );

endinterface

// File: rtl/lc3_mem_arbiter_rr_arb2.sv
// Two-requester round-robin picker. A lone request always wins; on a tie the
// requester that was not granted last time wins. The pointer moves only when
// the owner tells it a grant was actually taken (UPDATE).
module rr_arb2 (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [1:0] REQ,
  input  logic       UPDATE,
  output logic [1:0] WIN
);

  logic r_last_ls;

  // Winner selection: pass lone requests straight through, break ties by pointer.
  always_comb begin
    WIN = REQ;
    if (REQ == 2'b11) begin
      WIN = r_last_ls ? 2'b01 : 2'b10;
    end
  end

  // Remember who was granted last; reset points at LS so the fetch port wins the first tie.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_last_ls <= 1'b1;
    end else if (UPDATE && (REQ != 2'b00)) begin
      r_last_ls <= WIN[1];
    end
  end

endmodule

// File: rtl/lc3_mem_arbiter.sv
// LC-3 memory arbiter: shares the single-port level-sensitive RAM between the
// fetch unit and the load/store unit. A three-state FSM (IDLE/ACCESS/DONE)
// latches the winning request, holds the RAM address stable for the whole
// access and only raises RAM_WE inside ACCESS, so the RAM never sees a write
// to a transient address. Every output comes from a register.
module lc3_mem_arbiter
  import lc3_mem_pkg::*;
#(
  parameter int ADDR_SIZE   = 16,
  parameter int DATA_SIZE   = 16,
  parameter int WAIT_CYCLES = 1
) (
  input logic              CLK,
  input logic              RESET_N,
  lc3_mem_arbiter_if.slave bus
);

  // A zero wait count is treated as a single-cycle access.
  localparam int WAIT_EFF = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
  localparam int CNT_W    = (WAIT_EFF > 1) ? $clog2(WAIT_EFF) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_EFF - 1);

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [ADDR_SIZE-1:0] r_addr;
  logic [DATA_SIZE-1:0] r_wdata;
  logic                 r_we;
  logic                 r_ram_we;
  logic [1:0]           r_grant;
  logic                 r_busy;
  logic                 r_if_ack;
  logic                 r_ls_ack;
  logic [DATA_SIZE-1:0] r_if_rdata;
  logic [DATA_SIZE-1:0] r_ls_rdata;

  logic [1:0]           w_req;
  logic [1:0]           w_win;
  logic                 w_update;

  assign w_req    = {bus.LS_REQ, bus.IF_REQ};
  assign w_update = (r_state == S_IDLE);

  rr_arb2 u_arb (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .REQ     (w_req),
    .UPDATE  (w_update),
    .WIN     (w_win)
  );

  // Sequencer: arbitrate and latch in IDLE, count down in ACCESS, pulse ACK in DONE.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_ram_we   <= 1'b0;
      r_grant    <= GNT_NONE;
      r_busy     <= 1'b0;
      r_if_ack   <= 1'b0;
      r_ls_ack   <= 1'b0;
      r_if_rdata <= '0;
      r_ls_rdata <= '0;
    end else begin
      r_if_ack <= 1'b0;
      r_ls_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req != 2'b00) begin
            r_grant <= win_to_grant(w_win);
            if (w_win[1]) begin
              r_addr   <= bus.LS_ADDR;
              r_wdata  <= bus.LS_WDATA;
              r_we     <= bus.LS_WE;
              r_ram_we <= bus.LS_WE;
            end else begin
              r_addr   <= bus.IF_ADDR;
              r_wdata  <= '0;
              r_we     <= 1'b0;
              r_ram_we <= 1'b0;
            end
            r_cnt   <= CNT_LOAD;
            r_busy  <= 1'b1;
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (r_cnt == '0) begin
            if (r_grant == GNT_IF) begin
              r_if_rdata <= bus.RAM_DATA_OUT;
              r_if_ack   <= 1'b1;
            end else begin
              if (!r_we) begin
                r_ls_rdata <= bus.RAM_DATA_OUT;
              end
              r_ls_ack <= 1'b1;
            end
            r_ram_we <= 1'b0;
            r_state  <= S_DONE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_DONE: begin
          r_grant <= GNT_NONE;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_grant  <= GNT_NONE;
          r_busy   <= 1'b0;
          r_ram_we <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.RAM_WE      = r_ram_we;
  assign bus.RAM_ADDRESS = r_addr;
  assign bus.RAM_DATA_IN = r_wdata;
  assign bus.IF_RDATA    = r_if_rdata;
  assign bus.IF_ACK      = r_if_ack;
  assign bus.LS_RDATA    = r_ls_rdata;
  assign bus.LS_ACK      = r_ls_ack;
  assign bus.GRANT       = r_grant;
  assign bus.BUSY        = r_busy;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Testbench for lc3_mem_arbiter: a WAIT_CYCLES=1 instance with a RAM model for
// the directed table, reset, back-to-back and random traffic, plus a
// WAIT_CYCLES=3 instance for the longer-access timing.
module tb_lc3_mem_arbiter;

  localparam int W1 = 1;
  localparam int W3 = 3;

  logic CLK;
  logic RESET_N;

  int checks;
  int failures;
  int rrLast;
  logic [15:0] expIfR;
  logic [15:0] expLsR;
  logic [15:0] refMem [0:255];

  lc3_mem_arbiter_if #(.ADDR_SIZE(16), .DATA_SIZE(16)) bus ();
  lc3_mem_arbiter_if #(.ADDR_SIZE(16), .DATA_SIZE(16)) bus3 ();

  lc3_mem_arbiter #(.ADDR_SIZE(16), .DATA_SIZE(16), .WAIT_CYCLES(W1)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  lc3_mem_arbiter #(.ADDR_SIZE(16), .DATA_SIZE(16), .WAIT_CYCLES(W3)) dut3 (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus3)
  );

  typedef struct {
    bit          doIf;
    bit          doLs;
    logic [15:0] ifA;
    bit          lsWe;
    logic [15:0] lsA;
    logic [15:0] lsD;
    int          expFirst;
    logic [15:0] expIfR;
    logic [15:0] expLsR;
  } vec_t;

  vec_t vecs [7];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [15:0] initVal(input int a);
    logic [7:0] b;
    b = a[7:0];
    return {b, ~b};
  endfunction

  // RAM model for the WAIT_CYCLES=1 instance: combinational read, write on the clock while WE is high.
  logic [15:0] mem [0:255];
  bit memReady;
  always @(posedge CLK) begin
    if (!memReady) begin
      for (int i = 0; i < 256; i++) mem[i] <= initVal(i);
      mem[8] <= 16'h1226;
      memReady <= 1'b1;
    end else if (bus.RAM_WE) begin
      mem[bus.RAM_ADDRESS[7:0]] <= bus.RAM_DATA_IN;
    end
  end
  assign bus.RAM_DATA_OUT  = mem[bus.RAM_ADDRESS[7:0]];
  assign bus3.RAM_DATA_OUT = ~bus3.RAM_ADDRESS;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flagFail(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: event seen, required none", name);
  endtask

  // One transaction on the W=1 instance (IF, LS or both at once), checked against the reference model.
  task automatic applyStimulus(input bit doIf, input bit doLs, input logic [15:0] ifA,
                               input bit lsWe, input logic [15:0] lsA, input logic [15:0] lsD,
                               output int firstPort);
    int cyc, ifAt, lsAt, weCycles, expFirst, firstAt;
    bit ifDone, lsDone;
    if (doIf && doLs) expFirst = (rrLast == 2) ? 1 : 2;
    else expFirst = doIf ? 1 : 2;
    bus.IF_REQ = doIf; bus.IF_ADDR = ifA;
    bus.LS_REQ = doLs; bus.LS_WE = lsWe; bus.LS_ADDR = lsA; bus.LS_WDATA = lsD;
    ifDone = !doIf; lsDone = !doLs;
    ifAt = 0; lsAt = 0; weCycles = 0; cyc = 0; firstPort = 0;
    while (!(ifDone && lsDone) && cyc < 30) begin
      @(negedge CLK);
      cyc++;
      if (cyc == 1) check("grant_first", bus.GRANT, expFirst);
      if (bus.RAM_WE) weCycles++;
      if (bus.RAM_WE && (bus.IF_ACK || bus.LS_ACK)) flagFail("we_during_done");
      if (bus.IF_ACK) begin
        if (ifDone) flagFail("if_ack_extra");
        else begin
          ifDone = 1; ifAt = cyc; bus.IF_REQ = 1'b0;
          if (firstPort == 0) firstPort = 1;
          expIfR = refMem[ifA[7:0]];
          check("if_rdata", bus.IF_RDATA, expIfR);
          check("ls_rdata_at_if_ack", bus.LS_RDATA, expLsR);
        end
      end
      if (bus.LS_ACK) begin
        if (lsDone) flagFail("ls_ack_extra");
        else begin
          lsDone = 1; lsAt = cyc; bus.LS_REQ = 1'b0;
          if (firstPort == 0) firstPort = 2;
          if (lsWe) refMem[lsA[7:0]] = lsD;
          else expLsR = refMem[lsA[7:0]];
          check("ls_rdata", bus.LS_RDATA, expLsR);
          check("if_rdata_at_ls_ack", bus.IF_RDATA, expIfR);
        end
      end
    end
    if (!(ifDone && lsDone)) flagFail("ack_timeout");
    firstAt = (firstPort == 1) ? ifAt : lsAt;
    check("first_port", firstPort, expFirst);
    check("first_ack_latency", firstAt, W1 + 1);
    if (doIf && doLs) check("second_ack_gap", (ifAt > lsAt) ? ifAt - lsAt : lsAt - ifAt, W1 + 2);
    check("we_cycles", weCycles, (doLs && lsWe) ? W1 : 0);
    rrLast = (doIf && doLs) ? ((expFirst == 1) ? 2 : 1) : expFirst;
    bus.IF_REQ = 1'b0; bus.LS_REQ = 1'b0;
    @(negedge CLK);
    check("idle_busy", bus.BUSY, 0);
    check("idle_grant", bus.GRANT, 0);
    check("idle_we", bus.RAM_WE, 0);
  endtask

  task automatic checkOutput(input string tag);
    check({tag, "_if_rdata"}, bus.IF_RDATA, 0);
    check({tag, "_ls_rdata"}, bus.LS_RDATA, 0);
    check({tag, "_if_ack"}, bus.IF_ACK, 0);
    check({tag, "_ls_ack"}, bus.LS_ACK, 0);
    check({tag, "_ram_we"}, bus.RAM_WE, 0);
    check({tag, "_ram_addr"}, bus.RAM_ADDRESS, 0);
    check({tag, "_ram_din"}, bus.RAM_DATA_IN, 0);
    check({tag, "_grant"}, bus.GRANT, 0);
    check({tag, "_busy"}, bus.BUSY, 0);
  endtask

  initial begin
    int fp, cyc, ackCnt, prevAck, lowCnt, weCyc, sel;
    bit done;
    checks = 0; failures = 0; rrLast = 2; expIfR = '0; expLsR = '0;
    for (int i = 0; i < 256; i++) refMem[i] = initVal(i);
    refMem[8] = 16'h1226;
    bus.IF_REQ = 0; bus.IF_ADDR = '0; bus.LS_REQ = 0; bus.LS_WE = 0; bus.LS_ADDR = '0; bus.LS_WDATA = '0;
    bus3.IF_REQ = 0; bus3.IF_ADDR = '0; bus3.LS_REQ = 0; bus3.LS_WE = 0; bus3.LS_ADDR = '0; bus3.LS_WDATA = '0;

    RESET_N = 1'b0;
    repeat (3) @(negedge CLK);
    checkOutput("reset");
    check("reset3_busy", bus3.BUSY, 0);
    check("reset3_grant", bus3.GRANT, 0);
    RESET_N = 1'b1;
    @(negedge CLK);

    vecs[0] = '{1, 0, 16'h0008, 0, 16'h0000, 16'h0000, 1, 16'h1226, 16'h0000};
    vecs[1] = '{0, 1, 16'h0000, 1, 16'h0020, 16'hBEEF, 2, 16'h1226, 16'h0000};
    vecs[2] = '{0, 1, 16'h0000, 0, 16'h0020, 16'h0000, 2, 16'h1226, 16'hBEEF};
    vecs[3] = '{1, 1, 16'h0010, 0, 16'h0008, 16'h0000, 1, 16'h10EF, 16'h1226};
    vecs[4] = '{1, 0, 16'h0008, 0, 16'h0000, 16'h0000, 1, 16'h1226, 16'h1226};
    vecs[5] = '{1, 1, 16'h0010, 1, 16'h0010, 16'h4321, 2, 16'h4321, 16'h1226};
    vecs[6] = '{1, 1, 16'h0020, 0, 16'h0010, 16'h0000, 2, 16'hBEEF, 16'h4321};
    for (int v = 0; v < 7; v++) begin
      applyStimulus(vecs[v].doIf, vecs[v].doLs, vecs[v].ifA, vecs[v].lsWe, vecs[v].lsA, vecs[v].lsD, fp);
      check("vec_first", fp, vecs[v].expFirst);
      check("vec_if_rdata", bus.IF_RDATA, vecs[v].expIfR);
      check("vec_ls_rdata", bus.LS_RDATA, vecs[v].expLsR);
    end

    $display("[TB] WAIT_CYCLES=3 fetch and store");
    bus3.IF_REQ = 1'b1; bus3.IF_ADDR = 16'h0044;
    done = 0; cyc = 0;
    while (!done && cyc < 15) begin
      @(negedge CLK); cyc++;
      if (bus3.BUSY && !bus3.IF_ACK) check("w3_addr_stable", bus3.RAM_ADDRESS, 16'h0044);
      if (bus3.IF_ACK) begin
        done = 1; bus3.IF_REQ = 1'b0;
        check("w3_if_latency", cyc, W3 + 1);
        check("w3_if_rdata", bus3.IF_RDATA, 16'hFFBB);
      end
    end
    if (!done) flagFail("w3_if_timeout");
    @(negedge CLK);
    bus3.LS_REQ = 1'b1; bus3.LS_WE = 1'b1; bus3.LS_ADDR = 16'h0050; bus3.LS_WDATA = 16'h7777;
    done = 0; cyc = 0; weCyc = 0;
    while (!done && cyc < 15) begin
      @(negedge CLK); cyc++;
      if (bus3.RAM_WE) begin
        weCyc++;
        check("w3_din", bus3.RAM_DATA_IN, 16'h7777);
        check("w3_we_addr", bus3.RAM_ADDRESS, 16'h0050);
      end
      if (bus3.LS_ACK) begin
        done = 1; bus3.LS_REQ = 1'b0;
        check("w3_ls_latency", cyc, W3 + 1);
        check("w3_ls_rdata_kept", bus3.LS_RDATA, 16'h0000);
      end
    end
    if (!done) flagFail("w3_ls_timeout");
    check("w3_we_cycles", weCyc, W3);
    @(negedge CLK);

    $display("[TB] reset during a store access");
    bus.LS_REQ = 1'b1; bus.LS_WE = 1'b1; bus.LS_ADDR = 16'h0060; bus.LS_WDATA = 16'hDEAD;
    @(negedge CLK);
    check("mid_we_before", bus.RAM_WE, 1);
    #2 RESET_N = 1'b0;
    #1;
    check("mid_we_after", bus.RAM_WE, 0);
    check("mid_busy_after", bus.BUSY, 0);
    check("mid_grant_after", bus.GRANT, 0);
    check("mid_ack_after", bus.LS_ACK, 0);
    bus.LS_REQ = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b1;
    rrLast = 2; expIfR = '0; expLsR = '0;
    repeat (3) begin
      @(negedge CLK);
      if (bus.LS_ACK || bus.IF_ACK) flagFail("ack_after_reset");
    end
    applyStimulus(1, 1, 16'h0008, 0, 16'h0020, 16'h0000, fp);
    check("post_reset_tie", fp, 1);

    $display("[TB] LS request held for three accesses");
    bus.LS_REQ = 1'b1; bus.LS_WE = 1'b0; bus.LS_ADDR = 16'h0020;
    ackCnt = 0; prevAck = 0; lowCnt = 0; cyc = 0;
    while (ackCnt < 3 && cyc < 30) begin
      @(negedge CLK); cyc++;
      if (!bus.BUSY) lowCnt++;
      if (bus.LS_ACK) begin
        ackCnt++;
        check("b2b_rdata", bus.LS_RDATA, 16'hBEEF);
        if (ackCnt > 1) begin
          check("b2b_gap", cyc - prevAck, W1 + 2);
          check("b2b_busy_low", lowCnt, 1);
        end
        prevAck = cyc; lowCnt = 0;
        if (ackCnt == 3) bus.LS_REQ = 1'b0;
      end
    end
    if (ackCnt < 3) flagFail("b2b_timeout");
    rrLast = 2; expLsR = 16'hBEEF;
    @(negedge CLK);

    $display("[TB] random traffic");
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 2);
      applyStimulus(sel != 1, sel != 0, 16'($urandom_range(16'h40, 16'h5F)), 1'($urandom_range(0, 1)),
                    16'($urandom_range(16'h40, 16'h5F)), 16'($urandom), fp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
